// File: rtl/essential_bit_iter.sv
// Essential-bit sequencer: splits an 8-bit magnitude into one beat per set bit, MSB first.
// Optional build macro EBIT_ZERO_SKIP_EN: a zero input is swallowed instead of emitting a zero beat.
module essential_bit_iter #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_sign,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_idx,
    output logic             out_sign,
    output logic [TAG_W-1:0] out_tag,
    output logic [2:0]       out_cnt,
    output logic             out_last,
    output logic             out_zero
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [7:0]         mask;
    logic [2:0]         cnt;
    logic               sign_q;
    logic [TAG_W-1:0]   tag_q;
    logic               last_beat;
    logic               in_fire;
    logic               out_fire;
    logic               load;

    // Leading one in encoder convention: bit 7 -> 0, bit 0 -> 7.
    function automatic logic [2:0] lead_idx(input logic [7:0] m);
        logic [2:0] idx;
        logic       found;
        idx   = 3'd0;
        found = 1'b0;
        for (int b = 7; b >= 0; b--) begin
            if (m[b] && !found) begin
                idx   = 3'(7 - b);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    function automatic logic [7:0] clear_lead(input logic [7:0] m);
        logic [7:0] r;
        logic       found;
        r     = m;
        found = 1'b0;
        for (int b = 7; b >= 0; b--) begin
            if (m[b] && !found) begin
                r[b]  = 1'b0;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic is_single(input logic [7:0] m);
        return (m != 8'd0) && ((m & (m - 8'd1)) == 8'd0);
    endfunction

`ifdef EBIT_ZERO_SKIP_EN
    assign last_beat = is_single(mask);
    assign load      = in_fire && (in_data != 8'd0);
`else
    logic zero_q;
    // A zero transaction is a single beat flagged by zero_q with an empty mask.
    assign last_beat = zero_q || is_single(mask);
    assign load      = in_fire;
`endif

    assign out_fire = (state == RUN) && out_ready;
    assign in_ready = !reset && ((state == IDLE) || (out_fire && last_beat));
    assign in_fire  = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (load) state_nxt = RUN;
            end
            RUN: begin
                if (out_fire && last_beat) state_nxt = load ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask   <= 8'd0;
            cnt    <= 3'd0;
            sign_q <= 1'b0;
            tag_q  <= '0;
`ifndef EBIT_ZERO_SKIP_EN
            zero_q <= 1'b0;
`endif
        end else if (load) begin
            mask   <= in_data;
            cnt    <= 3'd0;
            sign_q <= in_sign;
            tag_q  <= in_tag;
`ifndef EBIT_ZERO_SKIP_EN
            zero_q <= (in_data == 8'd0);
`endif
        end else if (out_fire && !last_beat) begin
            mask <= clear_lead(mask);
            cnt  <= cnt + 3'd1;
        end
    end

    always_comb begin
        out_valid = (state == RUN);
        out_idx   = 3'd0;
        out_cnt   = 3'd0;
        out_last  = 1'b0;
        out_zero  = 1'b0;
        out_sign  = sign_q;
        out_tag   = tag_q;
        if (state == RUN) begin
            out_idx  = lead_idx(mask);
            out_cnt  = cnt;
            out_last = last_beat;
`ifndef EBIT_ZERO_SKIP_EN
            out_zero = zero_q;
`endif
        end
    end

endmodule

// File: tb/tb_essential_bit_iter.sv
// Scoreboard bench for essential_bit_iter: a bit-list reference model feeds an expected-beat
// queue that a negedge monitor drains whenever a beat transfers.
module tb_essential_bit_iter;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       in_data = 8'd0;
    logic             in_sign = 1'b0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [2:0]       out_idx;
    logic             out_sign;
    logic [TAG_W-1:0] out_tag;
    logic [2:0]       out_cnt;
    logic             out_last;
    logic             out_zero;

    essential_bit_iter #(.TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sign(in_sign), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .out_sign(out_sign), .out_tag(out_tag), .out_cnt(out_cnt),
        .out_last(out_last), .out_zero(out_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]       idx;
        logic [2:0]       cnt;
        logic             last;
        logic             sign;
        logic [TAG_W-1:0] tag;
        logic             zero;
    } beat_t;

    beat_t exp_q[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    beats_seen = 0;
    int    rdy_mode = 0;     // 0: always ready, 1: random, 2: from rdy_pat then ready
    logic  rdy_pat[$];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: one beat per set bit, scanned from bit 7 down.
    task automatic model_push(input logic [7:0] d, input logic s, input logic [TAG_W-1:0] t);
        int n;
        int k;
        beat_t bt;
        n = $countones(d);
        k = 0;
        if (d == 8'd0) begin
`ifndef EBIT_ZERO_SKIP_EN
            bt = '{idx: 3'd0, cnt: 3'd0, last: 1'b1, sign: s, tag: t, zero: 1'b1};
            exp_q.push_back(bt);
`endif
            return;
        end
        for (int b = 7; b >= 0; b--) begin
            if (d[b]) begin
                bt = '{idx: 3'(7 - b), cnt: 3'(k), last: (k == n - 1), sign: s, tag: t, zero: 1'b0};
                exp_q.push_back(bt);
                k++;
            end
        end
    endtask

    always @(negedge clk) begin
        if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
        else if (rdy_mode == 2 && rdy_pat.size() > 0) out_ready = rdy_pat.pop_front();
        else out_ready = 1'b1;
    end

    // Monitor: stability under stall, in_ready rule and beat contents.
    logic             p_stall = 1'b0;
    logic [2:0]       p_idx, p_cnt;
    logic             p_last, p_sign, p_zero;
    logic [TAG_W-1:0] p_tag;
    always @(negedge clk) begin
        beat_t h;
        #2;
        if (reset) begin
            p_stall = 1'b0;
        end else begin
            if (p_stall) begin
                chk("stall_valid", int'(out_valid), 1);
                chk("stall_idx", int'(out_idx), int'(p_idx));
                chk("stall_cnt", int'(out_cnt), int'(p_cnt));
                chk("stall_fields", int'({out_last, out_sign, out_zero, out_tag}),
                    int'({p_last, p_sign, p_zero, p_tag}));
            end
            if (!out_valid) begin
                chk("in_ready_idle", int'(in_ready), 1);
            end else if (exp_q.size() == 0) begin
                chk("unexpected_beat", int'(out_valid), 0);
            end else begin
                h = exp_q[0];
                chk("in_ready_run", int'(in_ready), int'(out_ready && h.last));
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    beats_seen++;
                    chk("idx", int'(out_idx), int'(h.idx));
                    chk("cnt", int'(out_cnt), int'(h.cnt));
                    chk("last", int'(out_last), int'(h.last));
                    chk("sign", int'(out_sign), int'(h.sign));
                    chk("tag", int'(out_tag), int'(h.tag));
                    chk("zero", int'(out_zero), int'(h.zero));
                end
            end
            p_stall = out_valid && !out_ready;
            p_idx = out_idx; p_cnt = out_cnt; p_last = out_last;
            p_sign = out_sign; p_zero = out_zero; p_tag = out_tag;
        end
    end

    task automatic send(input logic [7:0] d, input logic s, input logic [TAG_W-1:0] t);
        int budget;
        budget = 0;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_sign = s; in_tag = t;
        #1;
        while (!in_ready) begin
            @(negedge clk);
            #1;
            budget++;
            if (budget > 200) begin
                chk("accept_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
        end
        model_push(d, s, t);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
`ifdef EBIT_ZERO_SKIP_EN
        chk("first_beat_latency", int'(out_valid), int'(d != 8'd0 || exp_q.size() > 0));
`else
        chk("first_beat_latency", int'(out_valid), 1);
`endif
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (exp_q.size() > 0 && budget < 500) begin
            @(negedge clk);
            budget++;
        end
        if (exp_q.size() > 0) begin
            chk("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int seen0;
        int budget;
        logic [7:0] d;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_fields", int'({out_idx, out_cnt, out_last, out_zero, out_sign, out_tag}), 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", int'(in_ready), 1);

        // Three-beat transaction
        send(8'b1010_0001, 1'b1, 4'h5);
        drain();

        // 8'hFF then a single bit back to back
        send(8'hFF, 1'b0, 4'hA);
        send(8'h01, 1'b1, 4'h3);
        drain();

        // Stalls during a two-beat transaction
        rdy_mode = 2;
        rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        send(8'h48, 1'b0, 4'h9);
        drain();
        rdy_mode = 0;

        // Zero value
        send(8'h00, 1'b1, 4'hC);
`ifdef EBIT_ZERO_SKIP_EN
        chk("zero_skip_in_ready", int'(in_ready), 1);
`endif
        drain();

        // Reset after first beat of 8'hF0
        send(8'hF0, 1'b1, 4'h7);
        seen0 = beats_seen;
        budget = 0;
        while (beats_seen == seen0 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        chk("f0_first_beat", int'(beats_seen - seen0), 1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("midrun_rst_valid", int'(out_valid), 0);
            chk("midrun_rst_in_ready", int'(in_ready), 0);
        end
        reset = 1'b0;
        #1;
        chk("after_rst_in_ready", int'(in_ready), 1);
        repeat (4) @(negedge clk);

        // Random back-to-back stream
        rdy_mode = 1;
        for (int i = 0; i < 16; i++) begin
            d = 8'($urandom_range(1, 255));
            send(d, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end
        drain();
        rdy_mode = 0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
